// File: rtl/pi_dpi_position_tracker.sv
// Turns synchronised Pi DPI vsync/DE into active-pixel coordinates and a display enable,
// gated by a frame-geometry lock that must hold for LOCK_FRAMES frames.
module pi_dpi_position_tracker #(
  parameter int H_ACTIVE          = 720,
  parameter int V_ACTIVE          = 576,
  parameter int LOCK_FRAMES       = 2,
  parameter bit VSYNC_ACTIVE_HIGH = 1'b0
) (
  input  logic       sysClk,
  input  logic       reset,
  input  logic       pixelClkEn,
  input  logic       dpi_hsync,
  input  logic       dpi_vsync,
  input  logic       dpi_de,
  output logic [9:0] pixelX_pi,
  output logic [9:0] pixelY_pi,
  output logic       displayEnable_pi,
  output logic       frameLocked,
  output logic       geometryError
);

  localparam logic [10:0] H_W    = 11'(H_ACTIVE);
  localparam logic [10:0] V_W    = 11'(V_ACTIVE);
  localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);
  localparam logic [9:0]  SAT    = 10'd1023;

  typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_t;

  state_t     state_q;
  logic [3:0] good_q;
  logic       vs_act_q, de_q;
  logic [9:0] x_q, y_q;
  logic       bad_q, ovf_q;

  logic [9:0] x_d, y_inc, y_d;
  logic       ovf_inc;
  logic       vs_act, vs_lead, de_rise, de_fall;
  logic       line_bad, count_bad, frame_bad, drop_lock, lock_gain, locked_d, de_ok_d;

  // hsync carries no information the tracker needs; kept on the port for diagnostics.
  logic hsync_unused;
  assign hsync_unused = dpi_hsync;

  always_comb begin
    vs_act  = (dpi_vsync == VSYNC_ACTIVE_HIGH);
    vs_lead = vs_act && !vs_act_q;
    de_rise = dpi_de && !de_q;
    de_fall = !dpi_de && de_q;

    x_d = x_q;
    if (de_rise)
      x_d = '0;
    else if (dpi_de && x_q != SAT)
      x_d = x_q + 10'd1;

    line_bad = de_fall && (({1'b0, x_q} + 11'd1) != H_W);

    y_inc   = y_q;
    ovf_inc = ovf_q;
    if (de_fall) begin
      if (y_q == SAT)
        ovf_inc = 1'b1;
      else
        y_inc = y_q + 10'd1;
    end
    // A line ending on the vsync strobe still belongs to the frame being closed.
    y_d = vs_lead ? '0 : y_inc;

    count_bad = ovf_inc || ({1'b0, y_inc} != V_W);
    frame_bad = count_bad || bad_q || line_bad;
    drop_lock = line_bad || (vs_lead && count_bad);
    lock_gain = vs_lead && !frame_bad && ((good_q + 4'd1) == LOCK_N);

    locked_d = 1'b0;
    if (state_q == LOCKED)
      locked_d = !drop_lock;
    else if (state_q == MEASURE)
      locked_d = lock_gain;

    de_ok_d = dpi_de && locked_d && ({1'b0, x_d} < H_W) && ({1'b0, y_d} < V_W);
  end

  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      state_q          <= SEARCH;
      good_q           <= '0;
      vs_act_q         <= 1'b0;
      de_q             <= 1'b0;
      x_q              <= '0;
      y_q              <= '0;
      bad_q            <= 1'b0;
      ovf_q            <= 1'b0;
      pixelX_pi        <= '0;
      pixelY_pi        <= '0;
      displayEnable_pi <= 1'b0;
      geometryError    <= 1'b0;
    end else begin
      geometryError <= 1'b0;
      if (pixelClkEn) begin
        vs_act_q         <= vs_act;
        de_q             <= dpi_de;
        x_q              <= x_d;
        y_q              <= y_d;
        ovf_q            <= vs_lead ? 1'b0 : ovf_inc;
        bad_q            <= vs_lead ? 1'b0 : (bad_q | line_bad);
        pixelX_pi        <= x_d;
        pixelY_pi        <= y_d;
        displayEnable_pi <= de_ok_d;

        case (state_q)
          SEARCH: begin
            if (vs_lead) begin
              state_q <= MEASURE;
              good_q  <= '0;
            end
          end
          MEASURE: begin
            if (vs_lead) begin
              if (frame_bad) begin
                good_q        <= '0;
                geometryError <= 1'b1;
              end else begin
                good_q <= good_q + 4'd1;
                if (lock_gain)
                  state_q <= LOCKED;
              end
            end
          end
          LOCKED: begin
            if (drop_lock) begin
              state_q       <= SEARCH;
              good_q        <= '0;
              geometryError <= 1'b1;
            end
          end
          default: state_q <= SEARCH;
        endcase
      end
    end
  end

  assign frameLocked = (state_q == LOCKED);

endmodule

// File: tb/tb_pi_dpi_position_tracker.sv
// Drives scaled-down DPI frames into active-low and active-high vsync instances and checks
// both every cycle against a frame/line level model plus a few literal pins.
module tb_pi_dpi_position_tracker;
  localparam int H    = 12;
  localparam int V    = 6;
  localparam int LOCK = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, hs = 1'b0, vs_lo = 1'b1, de = 1'b0;
  logic vs_hi;
  assign vs_hi = ~vs_lo;

  logic [9:0] xa, ya, xb, yb;
  logic dea, lka, era, deb, lkb, erb;

  always #5 clk = ~clk;

  pi_dpi_position_tracker #(.H_ACTIVE(H), .V_ACTIVE(V), .LOCK_FRAMES(LOCK), .VSYNC_ACTIVE_HIGH(1'b0)) dut_lo (
    .sysClk(clk), .reset(rst), .pixelClkEn(en), .dpi_hsync(hs), .dpi_vsync(vs_lo), .dpi_de(de),
    .pixelX_pi(xa), .pixelY_pi(ya), .displayEnable_pi(dea), .frameLocked(lka), .geometryError(era));

  pi_dpi_position_tracker #(.H_ACTIVE(H), .V_ACTIVE(V), .LOCK_FRAMES(LOCK), .VSYNC_ACTIVE_HIGH(1'b1)) dut_hi (
    .sysClk(clk), .reset(rst), .pixelClkEn(en), .dpi_hsync(hs), .dpi_vsync(vs_hi), .dpi_de(de),
    .pixelX_pi(xb), .pixelY_pi(yb), .displayEnable_pi(deb), .frameLocked(lkb), .geometryError(erb));

  int n_cmp = 0, n_bad = 0;

  // Model state: 0 = search, 1 = measure, 2 = locked.
  int m_state = 0, m_good = 0, m_lines = 0, m_x = 0, m_y = 0, m_last_w = 0;
  bit m_frame_bad = 0, open_line = 0;
  int vs_count = 0, n_strobes = 0;

  logic [9:0] p_x = '0, p_y = '0, e_x, e_y;
  logic p_de = 0, p_lk = 0, p_err = 0, e_de, e_lk, e_err;

  int  first_x = 0, first_y = 0, last_x = 0, last_y = 0, lock_at = -1, err_pulses = 0, y_after_lead = 0;
  bit  seen_de = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e_x <= '0; e_y <= '0; e_de <= 1'b0; e_lk <= 1'b0; e_err <= 1'b0;
    end else begin
      e_err <= 1'b0;
      if (en) begin
        e_x <= p_x; e_y <= p_y; e_de <= p_de; e_lk <= p_lk; e_err <= p_err;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("x_lo", xa, e_x);   chk("y_lo", ya, e_y);   chk("de_lo", dea, e_de);
        chk("lock_lo", lka, e_lk); chk("err_lo", era, e_err);
        chk("x_hi", xb, e_x);   chk("y_hi", yb, e_y);   chk("de_hi", deb, e_de);
        chk("lock_hi", lkb, e_lk); chk("err_hi", erb, e_err);
        if (dea) begin
          if (!seen_de) begin first_x = xa; first_y = ya; seen_de = 1; end
          last_x = xa; last_y = ya;
        end
        if (lka && lock_at < 0) lock_at = vs_count;
        if (era) err_pulses++;
      end
    end
  endtask

  // One pixel strobe; lead/lend say whether this strobe opens a frame or closes a line.
  task automatic strobe(input bit vs_a, input bit d, input bit lead, input bit lend, input int xv);
    int st0;
    bit err;
    bit long_gap;
    n_strobes++;
    long_gap = (n_strobes % 37 == 0);
    en = 1'b0;
    repeat (long_gap ? 8 : 1) begin
      @(negedge clk);
      if (long_gap) begin de = ~de; vs_lo = ~vs_lo; end
    end
    @(negedge clk);
    st0 = m_state;
    err = 0;
    if (lend) begin
      m_lines++;
      if (m_last_w != H) begin
        m_frame_bad = 1;
        if (st0 == 2) begin m_state = 0; m_good = 0; err = 1; end
      end
    end
    if (lead) begin
      vs_count++;
      case (st0)
        0: begin m_state = 1; m_good = 0; end
        1: begin
          if (m_frame_bad || m_lines != V) begin m_good = 0; err = 1; end
          else begin m_good++; if (m_good == LOCK) m_state = 2; end
        end
        default: begin
          if (m_state == 2 && m_lines != V) begin m_state = 0; m_good = 0; err = 1; end
        end
      endcase
      m_lines = 0;
      m_frame_bad = 0;
    end
    if (d) m_x = (xv > 1023) ? 1023 : xv;
    m_y = (m_lines > 1023) ? 1023 : m_lines;
    p_x = 10'(m_x);
    p_y = 10'(m_y);
    p_lk = (m_state == 2);
    p_de = d && (m_state == 2) && (m_x < H) && (m_y < V);
    p_err = err;
    vs_lo = ~vs_a; de = d; hs = ~d;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic mid_reset();
    chk("locked_before_reset", lka, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_x", xa, 0); chk("rst_async_y", ya, 0); chk("rst_async_de", dea, 0);
    chk("rst_async_lock", lka, 0); chk("rst_async_err", era, 0); chk("rst_async_lock_hi", lkb, 0);
    de = 1'b0; vs_lo = 1'b1; en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_state = 0; m_good = 0; m_lines = 0; m_x = 0; m_y = 0; m_frame_bad = 0; open_line = 0;
    vs_count = 0;
  endtask

  task automatic frame(input int nl, input int bad_l, input int bad_w, input bit collide,
                       input bit chk_err, input int rst_l);
    for (int i = 0; i < 3; i++) begin
      strobe(1, 0, i == 0, (i == 0) && open_line, 0);
      if (i == 0) begin open_line = 0; y_after_lead = ya; end
    end
    repeat (2) strobe(0, 0, 0, 0, 0);
    for (int l = 0; l < nl; l++) begin
      int w;
      w = (l == bad_l) ? bad_w : H;
      for (int k = 0; k < w; k++) begin
        if (l == rst_l && k == 5) begin mid_reset(); return; end
        strobe(0, 1, 0, 0, k);
      end
      m_last_w = w;
      if (collide && l == nl - 1) begin
        open_line = 1;
      end else begin
        strobe(0, 0, 0, 1, 0);
        if (chk_err && l == bad_l) begin
          chk("bad_line_err_pulse", era, 1);
          chk("bad_line_unlock", lka, 0);
        end
        repeat (2) strobe(0, 0, 0, 0, 0);
      end
    end
    if (!collide) repeat (2) strobe(0, 0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      compare_loop();
    join_none
    repeat (2) @(negedge clk);
    chk("reset_x", xa, 0); chk("reset_y", ya, 0); chk("reset_de", dea, 0);
    chk("reset_lock", lka, 0); chk("reset_err", era, 0);
    rst = 1'b0;

    // Nominal lock: third vsync edge locks, next frame shows the full active window.
    lock_at = -1;
    frame(V, -1, 0, 0, 0, -1);
    frame(V, -1, 0, 0, 0, -1);
    chk("no_lock_after_two_edges", lka, 0);
    seen_de = 0;
    frame(V, -1, 0, 0, 0, -1);
    chk("lock_at_vsync_edge", lock_at, 3);
    chk("first_de_x", first_x, 0);   chk("first_de_y", first_y, 0);
    chk("last_de_x", last_x, H - 1); chk("last_de_y", last_y, V - 1);

    // Short line while locked, then relock after two clean frames.
    frame(V, 3, H - 1, 0, 1, -1);
    frame(V, -1, 0, 0, 0, -1);
    frame(V, -1, 0, 0, 0, -1);
    chk("no_relock_yet", lka, 0);
    frame(V, -1, 0, 0, 0, -1);
    chk("relocked", lka, 1);

    // Short frames: one while locked, one while measuring.
    err_pulses = 0;
    frame(V - 1, -1, 0, 0, 0, -1);
    frame(V, -1, 0, 0, 0, -1);
    frame(V - 1, -1, 0, 0, 0, -1);
    frame(V, -1, 0, 0, 0, -1);
    frame(V, -1, 0, 0, 0, -1);
    chk("lock_delayed_by_bad_frame", lka, 0);
    frame(V, -1, 0, 1, 0, -1);
    chk("count_error_pulses", err_pulses, 2);
    chk("lock_after_delay", lka, 1);

    // Vsync lands on the DE fall of the previous frame's last line.
    frame(V, -1, 0, 0, 0, -1);
    chk("collision_y_zero", y_after_lead, 0);

    // Over-long line saturates X and breaks lock.
    frame(V, V - 1, 1100, 0, 1, -1);
    chk("x_saturated_lo", xa, 1023);
    chk("x_saturated_hi", xb, 1023);

    // Relock, then reset mid-line; two good frames are needed after the next vsync.
    frame(V, -1, 0, 0, 0, -1);
    frame(V, -1, 0, 0, 0, -1);
    frame(V, -1, 0, 0, 0, -1);
    frame(V, -1, 0, 0, 0, 2);
    seen_de = 0;
    frame(V, -1, 0, 0, 0, -1);
    frame(V, -1, 0, 0, 0, -1);
    chk("no_de_before_relock", seen_de, 0);
    chk("no_lock_before_third_edge", lka, 0);
    frame(V, -1, 0, 0, 0, -1);
    chk("de_after_relock", seen_de, 1);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
